soc_design_pll_reset_sequencer: RTL

Reset and lock supervisor for the system PLL. It runs on the free-running board reference clock and drives the PLL's reset input. It monitors the PLL lock output and releases the system-domain and peripheral-domain resets in a fixed order once lock is stable. It also retries the PLL when lock is not achieved within a timeout, and re-sequences all resets on lock loss or a software reset request.

---
 rtl/soc_design_pll_reset_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/soc_design_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// soc_design_pll_reset_sequencer
//
// Reset and lock supervisor for the system PLL. Runs on the free-running
// reference clock, pulses the PLL reset, waits for a stable synchronised
// lock, and then releases the system-domain reset followed by the
// peripheral-domain reset. Retries the PLL on lock timeout and re-sequences
// on lock loss or on a software request.
//
// Ports:
//   clk            in   reference clock (also the PLL refclk)
//   reset_n        in   asynchronous active-low reset
//   pll_locked     in   PLL lock, asynchronous to clk
//   sw_reset_req   in   single-cycle request for a full re-sequence
//   lock_lost_clr  in   clears the sticky lock_lost flag
//   pll_rst        out  active-high PLL reset (registered)
//   sys_reset_n    out  active-low system-domain reset request (registered)
//   periph_reset_n out  active-low peripheral-domain reset request (registered)
//   status_locked  out  synchronised pll_locked
//   lock_lost      out  sticky: lock dropped while in REL_SYS or RUN
//   retry_count    out  number of lock timeouts, saturating at 255
// ---------------------------------------------------------------------------
module soc_design_pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_DELAY         = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  input  logic       lock_lost_clr,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       periph_reset_n,
  output logic       status_locked,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int CNT_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);

  // Counters compare against "last value before the transition" so that the
  // transition edge is exactly N edges after entering the state.
  localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [STAB_W-1:0] STAB_LAST    = STAB_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_REL_SYS   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STAB_W-1:0]        stab_q, stab_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     pll_rst_q, pll_rst_d;
  logic                     sys_reset_n_q, sys_reset_n_d;
  logic                     periph_reset_n_q, periph_reset_n_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [7:0]               retry_count_q, retry_count_d;

  logic                     locked_s;
  logic                     restart_s;
  logic                     lock_loss_s;
  logic                     timeout_s;
  logic                     clear_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_PLL_RST;
      cnt_q            <= '0;
      stab_q           <= '0;
      sync_q           <= '0;
      pll_rst_q        <= 1'b1;
      sys_reset_n_q    <= 1'b0;
      periph_reset_n_q <= 1'b0;
      lock_lost_q      <= 1'b0;
      retry_count_q    <= 8'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      stab_q           <= stab_d;
      sync_q           <= sync_d;
      pll_rst_q        <= pll_rst_d;
      sys_reset_n_q    <= sys_reset_n_d;
      periph_reset_n_q <= periph_reset_n_d;
      lock_lost_q      <= lock_lost_d;
      retry_count_q    <= retry_count_d;
    end
  end

  // Next-state logic: software request beats lock loss beats the timers.
  always_comb begin
    state_d     = state_q;
    restart_s   = 1'b0;
    lock_loss_s = 1'b0;
    timeout_s   = 1'b0;
    if (sw_reset_req) begin
      state_d   = ST_PLL_RST;
      restart_s = 1'b1;
    end else if (((state_q == ST_REL_SYS) || (state_q == ST_RUN)) && !locked_s) begin
      state_d     = ST_PLL_RST;
      lock_loss_s = 1'b1;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_PLL_RST;
          end
        end
        ST_WAIT_LOCK: begin
          // Stable lock wins over a coincident timeout.
          if (locked_s && (stab_q == STAB_LAST)) begin
            state_d = ST_REL_SYS;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = ST_PLL_RST;
            timeout_s = 1'b1;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_REL_SYS: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_REL_SYS;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_PLL_RST;
      endcase
    end
  end

  // Counters, synchroniser shift, sticky flag and retry counter.
  always_comb begin
    // A software request in PLL_RST restarts the count without a state change.
    clear_s = restart_s || (state_d != state_q);
    sync_d  = {sync_q[SYNC_STAGES-2:0], pll_locked};

    if (clear_s) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q;  // idle in RUN so it never wraps
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (clear_s) begin
      stab_d = '0;
    end else if ((state_q == ST_WAIT_LOCK) && locked_s) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      stab_d = '0;
    end

    // Set wins over clear.
    if (lock_loss_s) begin
      lock_lost_d = 1'b1;
    end else if (lock_lost_clr) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end

    if (timeout_s && (retry_count_q != 8'hFF)) begin
      retry_count_d = retry_count_q + 8'd1;
    end else begin
      retry_count_d = retry_count_q;
    end
  end

  // Output decode from the next state so outputs move on the transition edge.
  always_comb begin
    pll_rst_d        = 1'b1;
    sys_reset_n_d    = 1'b0;
    periph_reset_n_d = 1'b0;
    case (state_d)
      ST_PLL_RST: begin
        pll_rst_d        = 1'b1;
        sys_reset_n_d    = 1'b0;
        periph_reset_n_d = 1'b0;
      end
      ST_WAIT_LOCK: begin
        pll_rst_d        = 1'b0;
        sys_reset_n_d    = 1'b0;
        periph_reset_n_d = 1'b0;
      end
      ST_REL_SYS: begin
        pll_rst_d        = 1'b0;
        sys_reset_n_d    = 1'b1;
        periph_reset_n_d = 1'b0;
      end
      ST_RUN: begin
        pll_rst_d        = 1'b0;
        sys_reset_n_d    = 1'b1;
        periph_reset_n_d = 1'b1;
      end
      default: begin
        pll_rst_d        = 1'b1;
        sys_reset_n_d    = 1'b0;
        periph_reset_n_d = 1'b0;
      end
    endcase
  end

  assign pll_rst        = pll_rst_q;
  assign sys_reset_n    = sys_reset_n_q;
  assign periph_reset_n = periph_reset_n_q;
  assign status_locked  = locked_s;
  assign lock_lost      = lock_lost_q;
  assign retry_count    = retry_count_q;

endmodule
